// File: rtl/iq_sched_ctrl.sv
// Issue-queue slot allocator and one-per-cycle select; `IQ_AGE_SELECT_EN picks oldest-first, otherwise lowest index.
// Latency: allocation and select are combinational from registered occupancy; a freed slot is reusable the next cycle.
// Backpressure: disp_ready drops when all slots are full; the selected slot is held while issue_ready is low.
module iq_sched_ctrl #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               disp_valid,
  output logic               disp_ready,
  output logic [ENTRIES-1:0] entry_enq_valid,
  input  logic [ENTRIES-1:0] entry_ready,
  output logic               issue_valid,
  output logic [IDX_W-1:0]   issue_idx,
  input  logic               issue_ready,
  output logic [ENTRIES-1:0] entry_issuing,
  output logic [IDX_W:0]     occupancy,
  output logic               empty
);

  logic [ENTRIES-1:0] occ;
  logic [ENTRIES-1:0] cand;
  logic [ENTRIES-1:0] enq_oh;
  logic [ENTRIES-1:0] iss_oh;
  logic [IDX_W:0]     cnt;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   win_idx;
  logic               enq_fire;
  logic               iss_fire;

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!occ[i]) free_idx = IDX_W'(i);
    end
  end

  // Strobes are gated by reset_n so nothing reaches the entries while reset is held.
  assign disp_ready  = ~&occ & ~flush;
  assign enq_fire    = disp_valid & disp_ready & reset_n;
  assign cand        = entry_ready & occ;
  assign issue_valid = |cand & ~flush;
  assign iss_fire    = issue_valid & issue_ready & reset_n;

  assign enq_oh = enq_fire ? (ENTRIES'(1) << free_idx) : '0;
  assign iss_oh = iss_fire ? (ENTRIES'(1) << win_idx)  : '0;

`ifdef IQ_AGE_SELECT_EN
  logic [ENTRIES-1:0] age [ENTRIES];
  logic [ENTRIES-1:0] blocked;

  // A candidate is blocked if any other candidate is older than it.
  always_comb begin
    blocked = '0;
    win_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        blocked[i] = blocked[i] | (cand[j] & age[j][i]);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (cand[i] && !blocked[i]) win_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) age[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) age[i] <= '0;
    end else if (enq_fire) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (enq_oh[i]) age[i] <= '0;
        else           age[i][free_idx] <= occ[i];
      end
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  // Enqueue only targets a free slot and issue only an occupied one, so the masks never overlap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ <= '0;
      cnt <= '0;
    end else if (flush) begin
      occ <= '0;
      cnt <= '0;
    end else begin
      occ <= (occ | enq_oh) & ~iss_oh;
      cnt <= cnt + (IDX_W+1)'(enq_fire) - (IDX_W+1)'(iss_fire);
    end
  end

  assign entry_enq_valid = enq_oh;
  assign entry_issuing   = iss_oh;
  assign issue_idx       = win_idx;
  assign occupancy       = cnt;
  assign empty           = (cnt == '0);

endmodule

// File: tb/tb_iq_sched_ctrl.sv
// Directed bench for iq_sched_ctrl (ENTRIES=8); strobes are checked by a scoreboard monitor.
module tb_iq_sched_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       disp_valid;
  logic       disp_ready;
  logic [7:0] entry_enq_valid;
  logic [7:0] entry_ready;
  logic       issue_valid;
  logic [2:0] issue_idx;
  logic       issue_ready;
  logic [7:0] entry_issuing;
  logic [3:0] occupancy;
  logic       empty;

  int total = 0;
  int bad   = 0;
  logic [7:0] enq_q[$];
  logic [7:0] iss_q[$];

  iq_sched_ctrl #(.ENTRIES(8)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .entry_enq_valid(entry_enq_valid), .entry_ready(entry_ready),
    .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
    .entry_issuing(entry_issuing), .occupancy(occupancy), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic drive(input logic fl, input logic dv, input logic ir, input logic [7:0] er);
    @(posedge clock);
    #1;
    flush = fl; disp_valid = dv; issue_ready = ir; entry_ready = er;
    #2;
  endtask

  always @(negedge clock) begin
    if (entry_enq_valid != 8'h00) begin
      total++;
      if (enq_q.size() == 0) begin
        bad++;
        $display("FAIL enq_strobe: got %0h expected none", entry_enq_valid);
      end else begin
        logic [7:0] e;
        e = enq_q.pop_front();
        if (entry_enq_valid !== e) begin
          bad++;
          $display("FAIL enq_strobe: got %0h expected %0h", entry_enq_valid, e);
        end
      end
    end
    if (entry_issuing != 8'h00) begin
      total++;
      if (iss_q.size() == 0) begin
        bad++;
        $display("FAIL iss_strobe: got %0h expected none", entry_issuing);
      end else begin
        logic [7:0] e;
        e = iss_q.pop_front();
        if (entry_issuing !== e) begin
          bad++;
          $display("FAIL iss_strobe: got %0h expected %0h", entry_issuing, e);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_disp_ready"},  32'(disp_ready), 32'd1);
    chk({nm, "_issue_valid"}, 32'(issue_valid), 32'd0);
    chk({nm, "_issue_idx"},   32'(issue_idx), 32'd0);
    chk({nm, "_enq"},         32'(entry_enq_valid), 32'd0);
    chk({nm, "_iss"},         32'(entry_issuing), 32'd0);
    chk({nm, "_occ"},         32'(occupancy), 32'd0);
    chk({nm, "_empty"},       32'(empty), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0; entry_ready = 8'h00;
    #2;
    chk_reset_outputs("reset");
    #10 reset_n = 1'b1;

    // Fill all eight slots back to back, then a ninth offer must be refused.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 8'h00);
      chk("fill_disp_ready", 32'(disp_ready), 32'd1);
      enq_q.push_back(8'h01 << i);
    end
    drive(0, 1, 0, 8'h00);
    chk("full_occ", 32'(occupancy), 32'd8);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    chk("full_enq", 32'(entry_enq_valid), 32'd0);

    // Flush with dispatch and issue handshakes pending.
    drive(1, 1, 1, 8'hFF);
    chk("flush_enq", 32'(entry_enq_valid), 32'd0);
    chk("flush_iss", 32'(entry_issuing), 32'd0);
    chk("flush_issue_valid", 32'(issue_valid), 32'd0);
    chk("flush_disp_ready", 32'(disp_ready), 32'd0);
    drive(0, 1, 0, 8'h00);
    chk("post_flush_occ", 32'(occupancy), 32'd0);
    chk("post_flush_empty", 32'(empty), 32'd1);
    enq_q.push_back(8'h01);

    // Backpressure on a slot-3 candidate.
    for (int i = 1; i < 4; i++) begin
      drive(0, 1, 0, 8'h00);
      enq_q.push_back(8'h01 << i);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 8'h08);
      chk("bp_issue_valid", 32'(issue_valid), 32'd1);
      chk("bp_issue_idx", 32'(issue_idx), 32'd3);
      chk("bp_iss", 32'(entry_issuing), 32'd0);
    end
    drive(0, 0, 1, 8'h08);
    iss_q.push_back(8'h08);
    drive(0, 0, 1, 8'h08);
    chk("bp_after_issue_valid", 32'(issue_valid), 32'd0);
    chk("bp_after_occ", 32'(occupancy), 32'd3);

    // Enqueue and issue together at seven occupied slots.
    for (int i = 3; i < 7; i++) begin
      drive(0, 1, 0, 8'h00);
      enq_q.push_back(8'h01 << i);
    end
    drive(0, 1, 1, 8'h04);
    chk("sim_occ_before", 32'(occupancy), 32'd7);
    enq_q.push_back(8'h80);
    iss_q.push_back(8'h04);
    drive(0, 1, 0, 8'h00);
    chk("sim_occ_after", 32'(occupancy), 32'd7);
    chk("sim_disp_ready", 32'(disp_ready), 32'd1);
    enq_q.push_back(8'h04);

    // Full with an issue: disp_ready rises only the cycle after.
    drive(0, 1, 1, 8'h01);
    chk("full_iss_disp_ready", 32'(disp_ready), 32'd0);
    chk("full_iss_occ", 32'(occupancy), 32'd8);
    iss_q.push_back(8'h01);
    drive(0, 1, 0, 8'h00);
    chk("full_iss_next_ready", 32'(disp_ready), 32'd1);
    enq_q.push_back(8'h01);

    drive(0, 0, 1, 8'h02); iss_q.push_back(8'h02);
    drive(0, 0, 1, 8'h10); iss_q.push_back(8'h10);
    drive(0, 0, 1, 8'h20); iss_q.push_back(8'h20);
    drive(0, 0, 0, 8'h00);
    chk("pre_reset_occ", 32'(occupancy), 32'd5);

    // Asynchronous reset between edges, with handshakes being offered.
    reset_n = 1'b0; disp_valid = 1'b1; issue_ready = 1'b1; entry_ready = 8'hFF;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clock);
    #1;
    chk_reset_outputs("held_reset");
    disp_valid = 1'b0; issue_ready = 1'b0; entry_ready = 8'h00;
    reset_n = 1'b1;

    // Select order after slot 0 is reused.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 8'h00);
      enq_q.push_back(8'h01 << i);
    end
    drive(0, 0, 1, 8'h01);
    iss_q.push_back(8'h01);
    drive(0, 1, 0, 8'h00);
    enq_q.push_back(8'h01);
    drive(0, 0, 1, 8'h07);
`ifdef IQ_AGE_SELECT_EN
    chk("age_first_idx", 32'(issue_idx), 32'd1);
    iss_q.push_back(8'h02);
    drive(0, 0, 1, 8'h07); iss_q.push_back(8'h04);
    drive(0, 0, 1, 8'h07); iss_q.push_back(8'h01);
`else
    chk("age_first_idx", 32'(issue_idx), 32'd0);
    iss_q.push_back(8'h01);
    drive(0, 0, 1, 8'h07); iss_q.push_back(8'h02);
    drive(0, 0, 1, 8'h07); iss_q.push_back(8'h04);
`endif
    drive(0, 0, 0, 8'h00);
    chk("final_occ", 32'(occupancy), 32'd0);
    chk("final_empty", 32'(empty), 32'd1);

    repeat (3) drive(0, 0, 0, 8'h00);
    chk("enq_q_drained", 32'(enq_q.size()), 32'd0);
    chk("iss_q_drained", 32'(iss_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
